// File: rtl/ioctl_download_tx_if.sv
// ioctl_download_tx_if
//   Bundles the request, byte-source and ioctl download signals of
//   ioctl_download_tx.
//   master : transmitter side (drives ioctl_*, in_ready, busy, done, cksum)
//   slave  : host/source/receiver side (drives start, length, abort,
//            in_data, in_valid, ioctl_wait)
interface ioctl_download_tx_if #(
    parameter int unsigned ADDR_W = 25
) ();
    // Transfer request
    logic              start;
    logic [ADDR_W-1:0] length;
    logic              abort;

    // Byte source
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;

    // ioctl download port
    logic              ioctl_download;
    logic              ioctl_wr;
    logic [ADDR_W-1:0] ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic              ioctl_wait;

    // Status
    logic              busy;
    logic              done;
    logic [15:0]       cksum;

    modport master (
        input  start, length, abort, in_data, in_valid, ioctl_wait,
        output in_ready, ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
               busy, done, cksum
    );

    modport slave (
        output start, length, abort, in_data, in_valid, ioctl_wait,
        input  in_ready, ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
               busy, done, cksum
    );
endinterface

// File: rtl/ioctl_download_tx.sv
// ioctl_download_tx
//   Replays a byte stream into the hps_io-style ioctl download port:
//   ioctl_download frames the transfer, ioctl_wr is a one-cycle strobe with
//   ioctl_addr/ioctl_dout, strobes are spaced by at least WR_GAP idle cycles
//   and ioctl_wait stalls the next strobe.
//
//   Ports:
//     clk_sys  : system clock, rising edge
//     reset_n  : synchronous active-low reset
//     io       : ioctl_download_tx_if.master
//                start/length/abort   transfer request
//                in_data/in_valid/in_ready  byte source handshake
//                ioctl_download/ioctl_wr/ioctl_addr/ioctl_dout/ioctl_wait
//                busy/done/cksum      status
//
//   Optional feature: define IOCTL_TX_CKSUM_EN to accumulate a 16-bit byte
//   sum of the transfer on cksum; otherwise cksum is tied to zero.
module ioctl_download_tx #(
    parameter int unsigned ADDR_W = 25,
    parameter int unsigned WR_GAP = 3,
    parameter int unsigned TAIL   = 4
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    ioctl_download_tx_if.master   io
);

    localparam int unsigned GAP_W  = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;
    localparam int unsigned TAIL_W = (TAIL > 1) ? $clog2(TAIL) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_FETCH,
        S_STROBE,
        S_GAP,
        S_TAIL
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   remaining_q, remaining_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [TAIL_W-1:0]   tail_cnt_q, tail_cnt_d;

    logic                download_q, download_d;
    logic                wr_q, wr_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [ADDR_W-1:0]   ioctl_addr_q, ioctl_addr_d;
    logic [7:0]          ioctl_dout_q, ioctl_dout_d;

    // State register and all registered outputs
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            remaining_q  <= '0;
            addr_q       <= '0;
            gap_cnt_q    <= '0;
            tail_cnt_q   <= '0;
            download_q   <= 1'b0;
            wr_q         <= 1'b0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ioctl_addr_q <= '0;
            ioctl_dout_q <= '0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            addr_q       <= addr_d;
            gap_cnt_q    <= gap_cnt_d;
            tail_cnt_q   <= tail_cnt_d;
            download_q   <= download_d;
            wr_q         <= wr_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ioctl_addr_q <= ioctl_addr_d;
            ioctl_dout_q <= ioctl_dout_d;
        end
    end

    // Next-state, datapath and next-output logic
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        addr_d       = addr_q;
        gap_cnt_d    = gap_cnt_q;
        tail_cnt_d   = tail_cnt_q;
        ioctl_addr_d = ioctl_addr_q;
        ioctl_dout_d = ioctl_dout_q;

        if (io.abort && (state_q != S_IDLE)) begin
            // Abort beats every other condition in a busy state
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (io.start && !io.abort) begin
                        state_d     = S_ARM;
                        remaining_d = io.length;
                        addr_d      = '0;
                    end
                end
                S_ARM: begin
                    if (remaining_q == '0) begin
                        state_d    = S_TAIL;
                        tail_cnt_d = '0;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
                S_FETCH: begin
                    // Address and data are captured together so they stay
                    // stable for the strobe and hold afterwards.
                    if (io.in_valid) begin
                        state_d      = S_STROBE;
                        ioctl_dout_d = io.in_data;
                        ioctl_addr_d = addr_q;
                    end
                end
                S_STROBE: begin
                    state_d     = S_GAP;
                    addr_d      = addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - ADDR_W'(1);
                    gap_cnt_d   = '0;
                end
                S_GAP: begin
                    // Counter parks at its terminal value while ioctl_wait holds
                    if (gap_cnt_q == GAP_W'(WR_GAP - 1)) begin
                        if (!io.ioctl_wait) begin
                            if (remaining_q != '0) begin
                                state_d = S_FETCH;
                            end else begin
                                state_d    = S_TAIL;
                                tail_cnt_d = '0;
                            end
                        end
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    end
                end
                S_TAIL: begin
                    if (tail_cnt_q == TAIL_W'(TAIL - 1)) begin
                        state_d = S_IDLE;
                    end else begin
                        tail_cnt_d = tail_cnt_q + TAIL_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Outputs are decoded from the next state so they line up with it
        download_d = (state_d != S_IDLE);
        busy_d     = (state_d != S_IDLE);
        wr_d       = (state_d == S_STROBE);
        in_ready_d = (state_d == S_FETCH);
        done_d     = (state_q == S_TAIL) && (state_d == S_IDLE) && !io.abort;
    end

    assign io.ioctl_download = download_q;
    assign io.ioctl_wr       = wr_q;
    assign io.ioctl_addr     = ioctl_addr_q;
    assign io.ioctl_dout     = ioctl_dout_q;
    assign io.in_ready       = in_ready_q;
    assign io.busy           = busy_q;
    assign io.done           = done_q;

`ifdef IOCTL_TX_CKSUM_EN
    logic [15:0] cksum_q, cksum_d;
    logic        cksum_clr;
    logic        cksum_add;

    // Byte sum: cleared on an accepted start, bumped once per strobe
    always_comb begin
        cksum_clr = (state_q == S_IDLE) && io.start && !io.abort;
        cksum_add = (state_q == S_STROBE) && !io.abort;
        cksum_d   = cksum_q;
        if (cksum_clr) begin
            cksum_d = '0;
        end else if (cksum_add) begin
            cksum_d = cksum_q + {8'h00, ioctl_dout_q};
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            cksum_q <= '0;
        end else begin
            cksum_q <= cksum_d;
        end
    end

    assign io.cksum = cksum_q;
`else
    assign io.cksum = 16'h0000;
`endif

endmodule
